// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state encodings plus opcode helpers.
package alu_mc_pkg;

   typedef enum logic [4:0] {
      ADD    = 5'd0,
      SUB    = 5'd1,
      SLL    = 5'd2,
      SLT    = 5'd3,
      SLTU   = 5'd4,
      XOR    = 5'd5,
      SRL    = 5'd6,
      SRA    = 5'd7,
      OR     = 5'd8,
      AND    = 5'd9,
      MUL    = 5'd10,
      MULH   = 5'd11,
      MULHSU = 5'd12,
      MULHU  = 5'd13,
      DIV    = 5'd14,
      DIVU   = 5'd15,
      REM    = 5'd16,
      REMU   = 5'd17
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   function automatic logic is_mext(input alu_op_e op);
      return (op >= MUL) && (op <= REMU);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide core: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign correction on the finished result.
module mdu_iter
   import alu_mc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done_c,
   output logic [XLEN-1:0] result_c
);

   localparam int unsigned SHW = $clog2(XLEN);
   localparam int unsigned CW  = SHW + 1;

   alu_op_e         op_q;
   logic            div_q;
   logic            sign_a;
   logic            sign_b;
   logic            active;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] mb;

   logic            is_div_c;
   logic            sa_c;
   logic            sb_c;
   logic [XLEN-1:0] mag_a_c;
   logic [XLEN-1:0] mag_b_c;

   logic [XLEN:0]   msum;
   logic [XLEN:0]   dtrial;
   logic [XLEN:0]   ddiff;
   logic            dfit;
   logic [XLEN-1:0] hi_n;
   logic [XLEN-1:0] lo_n;

   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;

   // Operand signedness follows the RISC-V M definitions (MULHSU: A signed, B unsigned).
   assign is_div_c = (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
   assign sa_c     = a[XLEN-1] && ((op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM));
   assign sb_c     = b[XLEN-1] && ((op == MULH) || (op == DIV) || (op == REM));
   assign mag_a_c  = sa_c ? -a : a;
   assign mag_b_c  = sb_c ? -b : b;

   assign done_c = active && (cnt == CW'(XLEN - 1));

   // One iteration: hi/lo hold the partial product (multiplier in lo) or remainder/quotient.
   always_comb begin
      msum   = {1'b0, hi} + (lo[0] ? {1'b0, mb} : {(XLEN+1){1'b0}});
      dtrial = {hi, lo[XLEN-1]};
      ddiff  = dtrial - {1'b0, mb};
      dfit   = (dtrial >= {1'b0, mb});
      if (div_q) begin
         hi_n = XLEN'(dfit ? ddiff : dtrial);
         lo_n = {lo[XLEN-2:0], dfit};
      end else begin
         hi_n = msum[XLEN:1];
         lo_n = {msum[0], lo[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= ADD;
         div_q  <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         active <= 1'b0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         mb     <= '0;
      end else if (start) begin
         op_q   <= op;
         div_q  <= is_div_c;
         sign_a <= sa_c;
         sign_b <= sb_c;
         active <= 1'b1;
         cnt    <= '0;
         hi     <= '0;
         lo     <= is_div_c ? mag_a_c : mag_b_c;
         mb     <= is_div_c ? mag_b_c : mag_a_c;
      end else if (active) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt + CW'(1);
         if (done_c) begin
            active <= 1'b0;
         end
      end
   end

   // Sign correction: quotient takes sign(A)^sign(B), remainder takes sign(A).
   always_comb begin
      prod     = {hi, lo};
      prod_fix = (sign_a ^ sign_b) ? -prod : prod;
      quo_fix  = (sign_a ^ sign_b) ? -lo : lo;
      rem_fix  = sign_a ? -hi : hi;
      case (op_q)
         MUL:                 result_c = prod_fix[XLEN-1:0];
         MULH, MULHSU, MULHU: result_c = prod_fix[2*XLEN-1:XLEN];
         DIV, DIVU:           result_c = quo_fix;
         REM, REMU:           result_c = rem_fix;
         default:             result_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Define ALU_MC_MEXT_EN to build the iterative RV32M multiply/divide path.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  logic [4:0]      i_alu_op,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_alu_data,
   output logic            o_busy
);

   localparam int unsigned SHW = $clog2(XLEN);

   state_e          state;
   state_e          state_n;
   logic            valid_n;
   logic [XLEN-1:0] data_n;
   alu_op_e         op;
   logic [SHW-1:0]  shamt;
   logic            accept;
   logic [XLEN-1:0] base_c;
   logic            iter_c;
   logic [XLEN-1:0] result_c;

   assign op      = alu_op_e'(i_alu_op);
   assign shamt   = i_op_b[SHW-1:0];
   assign o_ready = (state == IDLE) && (!o_valid || i_ready);
   assign accept  = i_valid && o_ready;

   // Single-cycle base ALU; unassigned and (when not built) M-extension opcodes yield zero.
   always_comb begin
      base_c = '0;
      case (op)
         ADD:     base_c = i_op_a + i_op_b;
         SUB:     base_c = i_op_a - i_op_b;
         SLL:     base_c = i_op_a << shamt;
         SLT:     base_c = XLEN'($signed(i_op_a) < $signed(i_op_b));
         SLTU:    base_c = XLEN'(i_op_a < i_op_b);
         XOR:     base_c = i_op_a ^ i_op_b;
         SRL:     base_c = i_op_a >> shamt;
         SRA:     base_c = XLEN'($signed(i_op_a) >>> shamt);
         OR:      base_c = i_op_a | i_op_b;
         AND:     base_c = i_op_a & i_op_b;
         default: base_c = '0;
      endcase
   end

`ifdef ALU_MC_MEXT_EN
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic            div_zero_c;
   logic            div_ovf_c;
   logic            start;
   logic            mdu_done_c;
   logic [XLEN-1:0] mdu_result_c;

   // Divide-by-zero and signed overflow finish in IDLE without iterating.
   assign div_zero_c = ((op == DIV) || (op == DIVU) || (op == REM) || (op == REMU))
                       && (i_op_b == '0);
   assign div_ovf_c  = ((op == DIV) || (op == REM)) && (i_op_a == MIN_NEG) && (i_op_b == '1);
   assign iter_c     = is_mext(op) && !div_zero_c && !div_ovf_c;

   always_comb begin
      result_c = base_c;
      if (div_zero_c) begin
         result_c = ((op == DIV) || (op == DIVU)) ? '1 : i_op_a;
      end else if (div_ovf_c) begin
         result_c = (op == DIV) ? i_op_a : '0;
      end
   end

   mdu_iter #(
      .XLEN (XLEN)
   ) u_mdu (
      .clk      (i_clk),
      .rst      (i_reset),
      .start    (start),
      .op       (op),
      .a        (i_op_a),
      .b        (i_op_b),
      .done_c   (mdu_done_c),
      .result_c (mdu_result_c)
   );

   assign o_busy = (state != IDLE);
`else
   assign iter_c   = 1'b0;
   assign result_c = base_c;
   assign o_busy   = 1'b0;
`endif

   // Next state and output register; a drain and a new accept may share one edge.
   always_comb begin
      state_n = state;
      valid_n = o_valid;
      data_n  = o_alu_data;
`ifdef ALU_MC_MEXT_EN
      start   = 1'b0;
`endif
      if (o_valid && i_ready) begin
         valid_n = 1'b0;
      end
      case (state)
         IDLE: begin
            if (accept) begin
               if (iter_c) begin
`ifdef ALU_MC_MEXT_EN
                  start   = 1'b1;
`endif
                  state_n = CALC;
               end else begin
                  valid_n = 1'b1;
                  data_n  = result_c;
               end
            end
         end
`ifdef ALU_MC_MEXT_EN
         CALC: begin
            if (mdu_done_c) begin
               state_n = FIX;
            end
         end
         FIX: begin
            valid_n = 1'b1;
            data_n  = mdu_result_c;
            state_n = IDLE;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         o_valid    <= 1'b0;
         o_alu_data <= '0;
      end else begin
         state      <= state_n;
         o_valid    <= valid_n;
         o_alu_data <= data_n;
      end
   end

endmodule
